// File: rtl/tea_pkg.sv
// tea_pkg: widths and search FSM states shared by tea_key_search and tea_asmd
package tea_pkg;
    localparam int KEY_W   = 128;
    localparam int BLOCK_W = 64;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} search_state_t;
endpackage

// File: rtl/tea_key_search.sv
// tea_key_search: brute-force key search driving one tea_asmd core over a contiguous key range
module tea_key_search
    import tea_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               search_start,
    input  logic               abort,
    input  logic [KEY_W-1:0]   key_base,
    input  logic [CNT_W-1:0]   key_count,
    input  logic [BLOCK_W-1:0] cipher,
    output logic               core_start,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLOCK_W-1:0] core_data,
    input  logic               core_rdy,
    input  logic               core_valid,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               timeout_err,
    output logic [KEY_W-1:0]   found_key,
    output logic [CNT_W-1:0]   tried
);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    search_state_t    state, state_next;
    logic [CNT_W-1:0] count_r, idx;
    logic [WW-1:0]    wait_cnt;
    logic             last, tmo;

    assign last = (idx + CNT_W'(1)) == count_r;
    assign tmo  = !core_rdy && (wait_cnt == WW'(TIMEOUT_CYC - 1));

    // state register; ena freezes the FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (ena)
            state <= state_next;
    end

    // next state; abort outranks a same-cycle rdy, rdy is only looked at in WAIT
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (search_start) state_next = (key_count == '0) ? DONE : ISSUE;
            ISSUE: state_next = abort ? DONE : WAIT;
            WAIT:  if (abort || tmo || (core_rdy && (core_valid || last))) state_next = DONE;
                   else if (core_rdy) state_next = ISSUE;
            DONE:  state_next = IDLE;
        endcase
    end

    // registered outputs and datapath; the candidate key advances by increment, wrapping mod 2^128
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_start  <= 1'b0;
            core_key    <= '0;
            core_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            timeout_err <= 1'b0;
            found_key   <= '0;
            tried       <= '0;
            count_r     <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
        end else if (ena) begin
            core_start <= state_next == ISSUE;
            busy       <= state_next != IDLE;
            done       <= state_next == DONE;
            case (state)
                IDLE: if (search_start) begin
                    count_r     <= key_count;
                    core_key    <= key_base;
                    core_data   <= cipher;
                    found       <= 1'b0;
                    timeout_err <= 1'b0;
                    found_key   <= '0;
                    tried       <= '0;
                    idx         <= '0;
                end
                ISSUE: wait_cnt <= '0;
                WAIT: if (!abort) begin
                    if (core_rdy) begin
                        tried <= tried + CNT_W'(1);
                        if (core_valid) begin
                            found     <= 1'b1;
                            found_key <= core_key;
                        end else if (!last) begin
                            idx      <= idx + CNT_W'(1);
                            core_key <= core_key + KEY_W'(1);
                        end
                    end else if (tmo)
                        timeout_err <= 1'b1;
                    else
                        wait_cnt <= wait_cnt + WW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
